// File: rtl/flit_packetizer_if.sv
// Packet-in / flit-out handshake bundle for flit_packetizer.
// Flit layout, MSB first: flit_type[2], src_id, dst_id, pkt_id, flit_num, checksum, payload.
interface flit_packetizer_if #(
  parameter int MAX_PAYLOAD = 8,
  parameter int PAYLOAD_W   = 32,
  parameter int ID_W        = 8
);
  localparam int LEN_W  = $clog2(MAX_PAYLOAD + 1);
  localparam int FLIT_W = 2 + 3 * ID_W + LEN_W + 2 * PAYLOAD_W;

  logic                             pkt_valid;
  logic                             pkt_ready;
  logic [ID_W-1:0]                  pkt_src;
  logic [ID_W-1:0]                  pkt_dst;
  logic [LEN_W-1:0]                 pkt_len;
  logic [MAX_PAYLOAD*PAYLOAD_W-1:0] pkt_payload;
  logic [FLIT_W-1:0]                flit_out;
  logic                             flit_out_valid;
  logic                             flit_out_ready;

  // Driven by the packet source and the flit queue.
  modport master (
    output pkt_valid, pkt_src, pkt_dst, pkt_len, pkt_payload, flit_out_ready,
    input  pkt_ready, flit_out, flit_out_valid
  );

  // Seen by the packetizer.
  modport slave (
    input  pkt_valid, pkt_src, pkt_dst, pkt_len, pkt_payload, flit_out_ready,
    output pkt_ready, flit_out, flit_out_valid
  );
endinterface

// File: rtl/flit_packetizer.sv
// Serializes one packet into a head flit plus one flit per payload word.
// Optional macro FLIT_PACKETIZER_CHECKSUM_EN: XOR checksum on the TAIL/SINGLE flit.
module flit_packetizer #(
  parameter int MAX_PAYLOAD = 8,
  parameter int PAYLOAD_W   = 32,
  parameter int ID_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  flit_packetizer_if.slave   bus,
  output logic               busy,
  output logic               len_err
);
  localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PAYLOAD);

  typedef enum logic [1:0] {
    FT_HEAD   = 2'd0,
    FT_BODY   = 2'd1,
    FT_TAIL   = 2'd2,
    FT_SINGLE = 2'd3
  } flit_type_e;

  typedef struct packed {
    flit_type_e             flit_type;
    logic [ID_W-1:0]        src_id;
    logic [ID_W-1:0]        dst_id;
    logic [ID_W-1:0]        pkt_id;
    logic [LEN_W-1:0]       flit_num;
    logic [PAYLOAD_W-1:0]   checksum;
    logic [PAYLOAD_W-1:0]   payload;
  } flit_t;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_e;

  state_e                           state_q, state_d;
  logic [ID_W-1:0]                  src_q, src_d;
  logic [ID_W-1:0]                  dst_q, dst_d;
  logic [ID_W-1:0]                  pkt_id_q, pkt_id_d;
  logic [LEN_W-1:0]                 len_q, len_d;
  logic [LEN_W-1:0]                 num_q, num_d;
  logic [MAX_PAYLOAD*PAYLOAD_W-1:0] words_q, words_d;
  logic                             len_err_q, len_err_d;
  logic                             last_word;
  flit_t                            flit;
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
  logic [PAYLOAD_W-1:0]             csum_q, csum_d;
`endif

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    pkt_id_d  = pkt_id_q;
    len_d     = len_q;
    num_d     = num_q;
    words_d   = words_q;
    len_err_d = len_err_q;
    last_word = (num_q == len_q);
    flit      = '0;
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    if (state_q != IDLE) begin
      flit.src_id   = src_q;
      flit.dst_id   = dst_q;
      flit.pkt_id   = pkt_id_q;
      flit.flit_num = num_q;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.pkt_valid) begin
          src_d   = bus.pkt_src;
          dst_d   = bus.pkt_dst;
          words_d = bus.pkt_payload;
          num_d   = '0;
          if (bus.pkt_len > LEN_MAX) begin
            len_d     = LEN_MAX;
            len_err_d = 1'b1;
          end else begin
            len_d = bus.pkt_len;
          end
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
          csum_d = '0;
`endif
          state_d = HEAD;
        end
      end
      HEAD: begin
        flit.flit_type = (len_q == '0) ? FT_SINGLE : FT_HEAD;
        flit.payload   = PAYLOAD_W'(len_q);
        if (bus.flit_out_ready) begin
          if (len_q == '0) begin
            state_d  = IDLE;
            pkt_id_d = pkt_id_q + ID_W'(1);
          end else begin
            state_d = BODY;
            num_d   = LEN_W'(1);
          end
        end
      end
      BODY: begin
        // The current word always sits in the low slot; the store shifts down per handshake.
        flit.flit_type = last_word ? FT_TAIL : FT_BODY;
        flit.payload   = words_q[PAYLOAD_W-1:0];
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
        if (last_word) flit.checksum = csum_q ^ words_q[PAYLOAD_W-1:0];
`endif
        if (bus.flit_out_ready) begin
          words_d = words_q >> PAYLOAD_W;
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
          csum_d  = csum_q ^ words_q[PAYLOAD_W-1:0];
`endif
          if (last_word) begin
            state_d  = IDLE;
            pkt_id_d = pkt_id_q + ID_W'(1);
          end else begin
            num_d = num_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pkt_id_q  <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_id_q  <= pkt_id_d;
      len_err_q <= len_err_d;
    end
  end

  // NOTE: the captured packet store is not reset; it is always reloaded on accept before being read.
  always_ff @(posedge clk) begin
    src_q   <= src_d;
    dst_q   <= dst_d;
    len_q   <= len_d;
    num_q   <= num_d;
    words_q <= words_d;
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
    csum_q  <= csum_d;
`endif
  end

  assign bus.pkt_ready      = (state_q == IDLE);
  assign bus.flit_out_valid = (state_q != IDLE);
  assign bus.flit_out       = flit;
  assign busy               = (state_q != IDLE);
  assign len_err            = len_err_q;
endmodule

// File: tb/tb_flit_packetizer.sv
// Self-checking bench for flit_packetizer: packet-level reference model plus directed literal pins.
module tb_flit_packetizer;
  localparam int MAX_PAYLOAD = 8;
  localparam int PAYLOAD_W   = 32;
  localparam int ID_W        = 8;
  localparam int LEN_W       = $clog2(MAX_PAYLOAD + 1);
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef enum logic [1:0] {FT_HEAD = 2'd0, FT_BODY = 2'd1, FT_TAIL = 2'd2, FT_SINGLE = 2'd3} ft_e;
  typedef struct packed {
    ft_e                  flit_type;
    logic [ID_W-1:0]      src_id;
    logic [ID_W-1:0]      dst_id;
    logic [ID_W-1:0]      pkt_id;
    logic [LEN_W-1:0]     flit_num;
    logic [PAYLOAD_W-1:0] checksum;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic len_err;
  int   checks = 0;
  int   failures = 0;

  flit_packetizer_if #(.MAX_PAYLOAD(MAX_PAYLOAD), .PAYLOAD_W(PAYLOAD_W), .ID_W(ID_W)) bus ();

  flit_packetizer #(.MAX_PAYLOAD(MAX_PAYLOAD), .PAYLOAD_W(PAYLOAD_W), .ID_W(ID_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .len_err (len_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic flit_t mk_flit(input ft_e t, input logic [ID_W-1:0] s, input logic [ID_W-1:0] d,
                                    input logic [ID_W-1:0] id, input int num,
                                    input logic [PAYLOAD_W-1:0] cs, input logic [PAYLOAD_W-1:0] pl);
    flit_t f;
    f.flit_type = t;
    f.src_id    = s;
    f.dst_id    = d;
    f.pkt_id    = id;
    f.flit_num  = LEN_W'(num);
    f.checksum  = cs;
    f.payload   = pl;
    return f;
  endfunction

  // Reference model: on every packet accept, the full expected flit sequence is queued.
  flit_t           exp_q[$];
  logic [ID_W-1:0] m_pkt_id = '0;
  bit              m_len_err = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_pkt_id  = '0;
        m_len_err = 1'b0;
      end else begin
        check("pkt_ready", bus.pkt_ready, exp_q.size() == 0);
        check("flit_valid", bus.flit_out_valid, exp_q.size() != 0);
        check("busy", busy, exp_q.size() != 0);
        check("len_err", len_err, m_len_err);
        if (exp_q.size() != 0) begin
          check("flit", bus.flit_out, exp_q[0]);
          if (bus.flit_out_ready) begin
            if (exp_q[0].flit_type == FT_TAIL || exp_q[0].flit_type == FT_SINGLE) m_pkt_id++;
            void'(exp_q.pop_front());
          end
        end else if (bus.pkt_valid) begin
          int n;
          logic [PAYLOAD_W-1:0] w, cs;
          n = (int'(bus.pkt_len) > MAX_PAYLOAD) ? MAX_PAYLOAD : int'(bus.pkt_len);
          if (int'(bus.pkt_len) > MAX_PAYLOAD) m_len_err = 1'b1;
          exp_q.push_back(mk_flit(n == 0 ? FT_SINGLE : FT_HEAD, bus.pkt_src, bus.pkt_dst,
                                  m_pkt_id, 0, '0, PAYLOAD_W'(n)));
          cs = '0;
          for (int k = 1; k <= n; k++) begin
            w  = bus.pkt_payload[(k-1)*PAYLOAD_W +: PAYLOAD_W];
            cs = cs ^ w;
            exp_q.push_back(mk_flit(k == n ? FT_TAIL : FT_BODY, bus.pkt_src, bus.pkt_dst, m_pkt_id, k,
                                    (k == n && CSUM_EN) ? cs : '0, w));
          end
        end
      end
    end
  end

  task automatic send_pkt(input logic [ID_W-1:0] s, input logic [ID_W-1:0] d, input logic [LEN_W-1:0] l,
                          input logic [MAX_PAYLOAD*PAYLOAD_W-1:0] p);
    int n = 0;
    @(posedge clk); #1;
    while (!bus.pkt_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.pkt_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got pkt_ready=0 expected 1 within 200 cycles");
      return;
    end
    bus.pkt_src     = s;
    bus.pkt_dst     = d;
    bus.pkt_len     = l;
    bus.pkt_payload = p;
    bus.pkt_valid   = 1'b1;
    @(posedge clk); #1;
    bus.pkt_valid   = 1'b0;
    bus.pkt_src     = ID_W'($urandom);
    bus.pkt_len     = LEN_W'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.pkt_ready && !bus.flit_out_valid) return;
    end
    checks++;
    failures++;
    $display("FAIL idle_timeout: got busy after 200 cycles expected idle");
  endtask

  initial begin
    logic [MAX_PAYLOAD*PAYLOAD_W-1:0] p;
    logic [PAYLOAD_W-1:0] wa, wb, wc;
    wa = 32'h1111_0001;
    wb = 32'h2222_0010;
    wc = 32'h4444_0100;

    rst = 1'b1;
    bus.pkt_valid = 1'b0;
    bus.pkt_src = '0;
    bus.pkt_dst = '0;
    bus.pkt_len = '0;
    bus.pkt_payload = '0;
    bus.flit_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pkt_ready", bus.pkt_ready, 1);
    check("rst_valid", bus.flit_out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_len_err", len_err, 0);
    check("rst_flit", bus.flit_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // len=3: HEAD, A, B, TAIL C back to back
    p = '0;
    p[95:0] = {wc, wb, wa};
    send_pkt(8'd1, 8'd5, 4'd3, p);
    @(negedge clk); check("l3_head", bus.flit_out, mk_flit(FT_HEAD, 1, 5, 0, 0, 0, 32'd3));
    @(negedge clk); check("l3_body1", bus.flit_out, mk_flit(FT_BODY, 1, 5, 0, 1, 0, 32'h1111_0001));
    @(negedge clk); check("l3_body2", bus.flit_out, mk_flit(FT_BODY, 1, 5, 0, 2, 0, 32'h2222_0010));
    @(negedge clk); check("l3_tail", bus.flit_out,
                          mk_flit(FT_TAIL, 1, 5, 0, 3, CSUM_EN ? 32'h7777_0111 : 32'h0, 32'h4444_0100));

    // len=0: single SINGLE flit, pkt_ready back two cycles after accept
    send_pkt(8'd2, 8'd3, 4'd0, '0);
    @(negedge clk);
    check("l0_single", bus.flit_out, mk_flit(FT_SINGLE, 2, 3, 1, 0, 0, 0));
    check("l0_ready_busy", bus.pkt_ready, 0);
    @(negedge clk);
    check("l0_ready_back", bus.pkt_ready, 1);

    // Backpressure on BODY 1
    p = '0;
    p[63:0] = {32'hBBBB_0002, 32'hAAAA_0001};
    send_pkt(8'd7, 8'd9, 4'd2, p);
    @(posedge clk); #1;
    bus.flit_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", bus.flit_out, mk_flit(FT_BODY, 7, 9, 2, 1, 0, 32'hAAAA_0001));
    end
    @(posedge clk); #1;
    bus.flit_out_ready = 1'b1;
    @(negedge clk); check("bp_body1", bus.flit_out, mk_flit(FT_BODY, 7, 9, 2, 1, 0, 32'hAAAA_0001));
    @(negedge clk); check("bp_tail", bus.flit_out,
                          mk_flit(FT_TAIL, 7, 9, 2, 2, CSUM_EN ? 32'h1111_0003 : 32'h0, 32'hBBBB_0002));

    // Oversized length is clamped and flagged
    for (int k = 0; k < MAX_PAYLOAD; k++) p[k*PAYLOAD_W +: PAYLOAD_W] = 32'h0C00_0000 + PAYLOAD_W'(k + 1);
    send_pkt(8'd4, 8'd6, 4'd12, p);
    wait_idle();
    check("clamp_len_err", len_err, 1);
    send_pkt(8'd4, 8'd6, 4'd1, p);
    wait_idle();
    check("len_err_sticky", len_err, 1);

    // Reset mid-packet after two flits, then a clean len=1 packet
    send_pkt(8'd3, 8'd8, 4'd4, p);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", bus.flit_out_valid, 0);
    check("midrst_len_err", len_err, 0);
    p = '0;
    p[31:0] = 32'hDEAD_BEEF;
    send_pkt(8'd3, 8'd8, 4'd1, p);
    @(negedge clk); check("post_head", bus.flit_out, mk_flit(FT_HEAD, 3, 8, 0, 0, 0, 32'd1));
    @(negedge clk); check("post_tail", bus.flit_out,
                          mk_flit(FT_TAIL, 3, 8, 0, 1, CSUM_EN ? 32'hDEAD_BEEF : 32'h0, 32'hDEAD_BEEF));

    // pkt_id wrap: a stream of zero-length packets
    @(posedge clk); #1;
    bus.pkt_len   = '0;
    bus.pkt_valid = 1'b1;
    repeat (600) @(posedge clk);
    #1;
    bus.pkt_valid = 1'b0;
    wait_idle();

    // Randomized traffic, backpressure and occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst                = ($urandom_range(0, 299) == 0);
      bus.flit_out_ready = ($urandom_range(0, 3) != 0);
      bus.pkt_valid      = ($urandom_range(0, 2) == 0);
      bus.pkt_src        = ID_W'($urandom);
      bus.pkt_dst        = ID_W'($urandom);
      bus.pkt_len        = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(9, 15))
                                                       : LEN_W'($urandom_range(0, MAX_PAYLOAD));
      for (int k = 0; k < MAX_PAYLOAD; k++) bus.pkt_payload[k*PAYLOAD_W +: PAYLOAD_W] = $urandom;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.pkt_valid = 1'b0;
    bus.flit_out_ready = 1'b1;
    wait_idle();
    @(negedge clk);
    check("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
